// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the dual-issue pipeline.
//
// This stage registers the two-lane memory-to-write-back bus and passes both
// lanes' register-file writes straight through. It owns the architectural
// HI/LO registers. It also serialises the two retiring lanes onto the
// single-lane debug trace port. When both lanes retire together, it raises
// stallreq_trace for one cycle so that the second lane can be traced in the
// following cycle.
//
// Handshake: the trace port has no ready signal. stallreq_trace is a
// combinational request to the controller. The controller is expected to
// answer in the same cycle by setting stall[4]=Stop and stall[5]=NoStop.
// That makes the input register load a bubble at the next edge, while the
// pending lane is shown on the trace port.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   flush               clears the input register
//   stall[STALL_W-1:0]  bit 4 = this stage's input, bit 5 = sink (1 = Stop)
//   mem_to_wb_bus       {lane2, lane1}, each LANE_W bits
//   wb_to_rf_bus        {l2 we,waddr,wdata, l1 we,waddr,wdata}
//   hi_o, lo_o          architectural HI/LO
//   stallreq_trace      one-cycle stall request for dual retirement
//   debug_wb_*          serialised trace port
module wb_stage #(
  parameter int STALL_W = 6,
  parameter int LANE_W  = 136
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [STALL_W-1:0]    stall,
  input  logic [2*LANE_W-1:0]   mem_to_wb_bus,
  output logic [75:0]           wb_to_rf_bus,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  stallreq_trace,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_PEND = 1'b1} state_e;

  logic [2*LANE_W-1:0] in_q, in_d;
  logic [31:0]         hi_q, hi_d, lo_q, lo_d;
  logic [69:0]         pend_q, pend_d;   // {pc, we, waddr, wdata} of held lane2
  state_e              state_q, state_d;

  logic [LANE_W-1:0]   l1, l2;
  logic                l1_v, l2_v;
  logic [69:0]         trace_sel;

  assign l1   = in_q[LANE_W-1:0];
  assign l2   = in_q[2*LANE_W-1:LANE_W];
  // Bubbles carry pc = 0, so a nonzero pc marks a live lane.
  assign l1_v = (l1[69:38] != 32'd0);
  assign l2_v = (l2[69:38] != 32'd0);

  // Input register.
  always_comb begin
    in_d = in_q;
    if (flush) begin
      in_d = '0;
    end else if (stall[4] && !stall[5]) begin
      in_d = '0;
    end else if (!stall[4]) begin
      in_d = mem_to_wb_bus;
    end
  end

  // Register-file writes go straight through. A same-address collision is
  // resolved inside the register file, where lane2 wins.
  assign wb_to_rf_bus = {l2[37:0], l1[37:0]};

  // HI/LO: lane2 is younger, so its per-field writes override lane1's.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (l1_v && l1[135]) hi_d = l1[133:102];
    if (l1_v && l1[134]) lo_d = l1[101:70];
    if (l2_v && l2[135]) hi_d = l2[133:102];
    if (l2_v && l2[134]) lo_d = l2[101:70];
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // Trace FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      state_q <= S_IDLE;
    end else begin
      in_q    <= in_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      state_q <= state_d;
    end
  end

  // Trace FSM: next state.
  // PEND lasts exactly one cycle. The held lane is already committed, so a
  // flush arriving during PEND does not cancel it.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (l1_v && l2_v) begin
          state_d = S_PEND;
          pend_d  = l2[69:0];
        end
      end
      S_PEND:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Trace FSM: outputs.
  // While in PEND, the input register should hold a bubble. Any lanes it
  // holds anyway are not traced.
  always_comb begin
    stallreq_trace = 1'b0;
    trace_sel      = '0;
    case (state_q)
      S_IDLE: begin
        if (l1_v && l2_v) begin
          stallreq_trace = 1'b1;
          trace_sel      = l1[69:0];
        end else if (l1_v) begin
          trace_sel = l1[69:0];
        end else if (l2_v) begin
          trace_sel = l2[69:0];
        end
      end
      S_PEND:  trace_sel = pend_q;
      default: trace_sel = '0;
    endcase
  end

  assign debug_wb_pc       = trace_sel[69:38];
  assign debug_wb_rf_wen   = {4{trace_sel[37]}};
  assign debug_wb_rf_wnum  = trace_sel[36:32];
  assign debug_wb_rf_wdata = trace_sel[31:0];

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage.
//
// Inputs are driven 1 time unit after the rising edge. Inline checks are
// made at that same point. Trace records are pushed into exp_q in retirement
// order when a lane is driven. A negedge monitor pops one record and compares
// it whenever the trace port shows a nonzero pc.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [5:0]   stall;
  logic [271:0] mem_to_wb_bus;
  logic [75:0]  wb_to_rf_bus;
  logic [31:0]  hi_o, lo_o;
  logic         stallreq_trace;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;
  logic [72:0] exp_q[$];
  logic [72:0] mon_obs, mon_exp;

  always #5 clk = ~clk;

  wb_stage #(.STALL_W(6), .LANE_W(136)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .mem_to_wb_bus(mem_to_wb_bus), .wb_to_rf_bus(wb_to_rf_bus),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_trace(stallreq_trace),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  function automatic logic [135:0] mk_lane(input logic [31:0] pc, input logic we,
      input logic [4:0] wa, input logic [31:0] wd, input logic hw, input logic lw,
      input logic [31:0] hi, input logic [31:0] lo);
    return {hw, lw, hi, lo, pc, we, wa, wd};
  endfunction

  function automatic logic [72:0] trace_of(input logic [135:0] l);
    return {l[69:38], {4{l[37]}}, l[36:32], l[31:0]};
  endfunction

  function automatic logic [135:0] rand_lane();
    logic [135:0] l;
    if ($urandom_range(0, 2) == 0) return '0;
    l = mk_lane($urandom | 32'h4, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom);
    return l;
  endfunction

  // Trace scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b1 && debug_wb_pc !== 32'd0) begin
      mon_obs = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trace_unexpected got %h expected nothing", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          errors++;
          $display("FAIL trace_record got %h expected %h", mon_obs, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    stall = 6'($urandom_range(0, 63));
    for (int i = 0; i < 8; i++) mem_to_wb_bus[i*32 +: 32] = $urandom | 32'h4;
    mem_to_wb_bus[271:256] = 16'($urandom_range(0, 65535));
    repeat (3) step();
    checks++;
    if ({wb_to_rf_bus, hi_o, lo_o, stallreq_trace, debug_wb_pc, debug_wb_rf_wen,
         debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rf=%h hi=%h lo=%h sr=%b pc=%h expected all 0",
               wb_to_rf_bus, hi_o, lo_o, stallreq_trace, debug_wb_pc);
    end
    checks++;
    if (dut.state_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %b expected 0", dut.state_q);
    end
    rst = 1'b1;
    stall = '0;
    mem_to_wb_bus = '0;
    step();
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || debug_wb_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_release got hi=%h lo=%h pc=%h expected 0", hi_o, lo_o, debug_wb_pc);
    end
  endtask

  task automatic test_single_lane();
    logic [135:0] l1;
    l1 = mk_lane(32'hBFC00004, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_to_wb_bus = {136'd0, l1};
    exp_q.push_back(trace_of(l1));
    step();
    mem_to_wb_bus = '0;
    checks++;
    if (stallreq_trace !== 1'b0 || debug_wb_rf_wen !== 4'hF || debug_wb_rf_wnum !== 5'd5) begin
      errors++;
      $display("FAIL single_lane got sr=%b wen=%h wnum=%0d expected sr=0 wen=f wnum=5",
               stallreq_trace, debug_wb_rf_wen, debug_wb_rf_wnum);
    end
    checks++;
    if (wb_to_rf_bus !== {38'd0, 1'b1, 5'd5, 32'h1234}) begin
      errors++;
      $display("FAIL single_rf_bus got %h", wb_to_rf_bus);
    end
    step();
  endtask

  task automatic test_dual_retire();
    logic [135:0] l1, l2;
    l1 = mk_lane(32'hBFC00010, 1'b1, 5'd3, 32'hA, 1'b0, 1'b0, 32'd0, 32'd0);
    l2 = mk_lane(32'hBFC00014, 1'b1, 5'd4, 32'hB, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_to_wb_bus = {l2, l1};
    exp_q.push_back(trace_of(l1));
    exp_q.push_back(trace_of(l2));
    step();
    checks++;
    if (stallreq_trace !== 1'b1 || debug_wb_pc !== 32'hBFC00010) begin
      errors++;
      $display("FAIL dual_cycle1 got sr=%b pc=%h expected sr=1 pc=bfc00010",
               stallreq_trace, debug_wb_pc);
    end
    checks++;
    if (wb_to_rf_bus !== {1'b1, 5'd4, 32'hB, 1'b1, 5'd3, 32'hA}) begin
      errors++;
      $display("FAIL dual_rf_bus got %h", wb_to_rf_bus);
    end
    stall = 6'b010000;
    step();
    checks++;
    if (stallreq_trace !== 1'b0 || debug_wb_pc !== 32'hBFC00014 || debug_wb_rf_wnum !== 5'd4) begin
      errors++;
      $display("FAIL dual_cycle2 got sr=%b pc=%h wnum=%0d expected sr=0 pc=bfc00014 wnum=4",
               stallreq_trace, debug_wb_pc, debug_wb_rf_wnum);
    end
    checks++;
    if (wb_to_rf_bus !== 76'd0) begin
      errors++;
      $display("FAIL dual_bubble got %h expected 0", wb_to_rf_bus);
    end
    stall = '0;
    mem_to_wb_bus = '0;
    step();
    checks++;
    if (dut.state_q !== 1'b0 || debug_wb_pc !== 32'd0) begin
      errors++;
      $display("FAIL dual_return_idle got state=%b pc=%h expected 0", dut.state_q, debug_wb_pc);
    end
  endtask

  task automatic test_hilo_priority();
    logic [135:0] l1, l2;
    l1 = mk_lane(32'hBFC00020, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd1, 32'd2);
    l2 = mk_lane(32'hBFC00024, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd3);
    mem_to_wb_bus = {l2, l1};
    exp_q.push_back(trace_of(l1));
    exp_q.push_back(trace_of(l2));
    step();
    stall = 6'b010000;
    step();
    checks++;
    if (hi_o !== 32'd1 || lo_o !== 32'd3) begin
      errors++;
      $display("FAIL hilo_priority got hi=%h lo=%h expected hi=1 lo=3", hi_o, lo_o);
    end
    stall = '0;
    mem_to_wb_bus = '0;
    step();
  endtask

  task automatic test_flush_pend();
    logic [135:0] l1, l2;
    l1 = mk_lane(32'hBFC00030, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 32'd0, 32'd0);
    l2 = mk_lane(32'hBFC00034, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_to_wb_bus = {l2, l1};
    exp_q.push_back(trace_of(l1));
    exp_q.push_back(trace_of(l2));
    step();
    stall = 6'b010000;
    step();
    checks++;
    if (debug_wb_pc !== 32'hBFC00034 || stallreq_trace !== 1'b0) begin
      errors++;
      $display("FAIL flush_pend_trace got pc=%h sr=%b expected bfc00034 sr=0",
               debug_wb_pc, stallreq_trace);
    end
    // A flush arrives while the pending lane is shown. The new pair must be dropped.
    flush = 1'b1;
    stall = '0;
    mem_to_wb_bus = {mk_lane(32'hBFC00104, 1'b1, 5'd2, 32'h2, 1'b0, 1'b0, 32'd0, 32'd0),
                     mk_lane(32'hBFC00100, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0, 32'd0, 32'd0)};
    step();
    flush = 1'b0;
    mem_to_wb_bus = '0;
    checks++;
    if (wb_to_rf_bus !== 76'd0 || stallreq_trace !== 1'b0 || debug_wb_pc !== 32'd0) begin
      errors++;
      $display("FAIL flush_clear got rf=%h sr=%b pc=%h expected 0", wb_to_rf_bus,
               stallreq_trace, debug_wb_pc);
    end
    step();
    checks++;
    if (stallreq_trace !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_stallreq got %b expected 0", stallreq_trace);
    end
  endtask

  task automatic test_bubble_hold();
    logic [135:0] l1;
    l1 = mk_lane(32'hBFC00040, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_to_wb_bus = {136'd0, l1};
    exp_q.push_back(trace_of(l1));
    exp_q.push_back(trace_of(l1));
    step();
    stall = 6'b110000;
    mem_to_wb_bus = {136'd0, mk_lane(32'hBFC00200, 1'b1, 5'd11, 32'h5, 1'b0, 1'b0, 32'd0, 32'd0)};
    step();
    checks++;
    if (wb_to_rf_bus !== {38'd0, l1[37:0]}) begin
      errors++;
      $display("FAIL hold_keeps got %h expected %h", wb_to_rf_bus, {38'd0, l1[37:0]});
    end
    stall = 6'b010000;
    step();
    checks++;
    if (wb_to_rf_bus !== 76'd0 || debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0) begin
      errors++;
      $display("FAIL bubble_zero got rf=%h pc=%h wen=%h expected 0", wb_to_rf_bus,
               debug_wb_pc, debug_wb_rf_wen);
    end
    stall = '0;
    mem_to_wb_bus = '0;
    step();
  endtask

  task automatic test_reset_mid_pend();
    logic [135:0] l1, l2;
    l1 = mk_lane(32'hBFC00050, 1'b1, 5'd10, 32'h1010, 1'b1, 1'b1, 32'd5, 32'd6);
    l2 = mk_lane(32'hBFC00054, 1'b1, 5'd12, 32'h1212, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_to_wb_bus = {l2, l1};
    exp_q.push_back(trace_of(l1));
    step();
    stall = 6'b010000;
    step();
    checks++;
    if (hi_o !== 32'd5 || lo_o !== 32'd6 || dut.state_q !== 1'b1) begin
      errors++;
      $display("FAIL pend_setup got hi=%h lo=%h state=%b expected 5 6 1", hi_o, lo_o, dut.state_q);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_to_rf_bus, hi_o, lo_o, stallreq_trace, debug_wb_pc, debug_wb_rf_wen,
         debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0 || dut.state_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pend got pc=%h hi=%h state=%b expected 0",
               debug_wb_pc, hi_o, dut.state_q);
    end
    rst = 1'b1;
    stall = '0;
    mem_to_wb_bus = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [271:0] cur_in, next_in;
    logic [135:0] a, b;
    logic [31:0] m_hi, m_lo;
    logic m_pend, exp_sr, v1, v2;
    cur_in = '0;
    m_hi = '0;
    m_lo = '0;
    m_pend = 1'b0;
    for (int n = 0; n < 200; n++) begin
      a = cur_in[135:0];
      b = cur_in[271:136];
      v1 = (a[69:38] != 0);
      v2 = (b[69:38] != 0);
      exp_sr = !m_pend && v1 && v2;
      checks++;
      if (stallreq_trace !== exp_sr || hi_o !== m_hi || lo_o !== m_lo) begin
        errors++;
        $display("FAIL b2b_state n=%0d got sr=%b hi=%h lo=%h expected sr=%b hi=%h lo=%h",
                 n, stallreq_trace, hi_o, lo_o, exp_sr, m_hi, m_lo);
      end
      checks++;
      if (wb_to_rf_bus !== {b[37:0], a[37:0]}) begin
        errors++;
        $display("FAIL b2b_rf_bus n=%0d got %h expected %h", n, wb_to_rf_bus, {b[37:0], a[37:0]});
      end
      if (v1 && a[135]) m_hi = a[133:102];
      if (v1 && a[134]) m_lo = a[101:70];
      if (v2 && b[135]) m_hi = b[133:102];
      if (v2 && b[134]) m_lo = b[101:70];
      m_pend = exp_sr;
      if (exp_sr) begin
        stall = 6'b010000;
        next_in = '0;
      end else begin
        stall = '0;
        a = rand_lane();
        b = rand_lane();
        mem_to_wb_bus = {b, a};
        if (a[69:38] != 0) exp_q.push_back(trace_of(a));
        if (b[69:38] != 0) exp_q.push_back(trace_of(b));
        next_in = {b, a};
      end
      step();
      cur_in = next_in;
    end
    // The last load may be a pair, so allow it time to serialise.
    stall = '0;
    mem_to_wb_bus = '0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    stall = '0;
    mem_to_wb_bus = '0;
    test_reset();
    test_single_lane();
    test_dual_retire();
    test_hilo_priority();
    test_flush_pend();
    test_bubble_hold();
    test_reset_mid_pend();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL trace_drain got %0d pending records expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
